// File: rtl/rx_filtered_samples_wr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rx_filtered_samples_wr_ctrl_pkg
// Shared constants and types for the rx filtered-sample buffer:
//   sample width, BRAM address width, block length and the lock FSM encoding.
// No ports.
// -----------------------------------------------------------------------------
package rx_filtered_samples_wr_ctrl_pkg;

  localparam int RX_FILT_DATA_W    = 16;
  localparam int RX_FILT_ADDR_W    = 9;
  localparam int RX_FILT_BLOCK_LEN = 128;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_LOCKED = 2'd2
  } lock_state_e;

endpackage

// File: rtl/rx_filtered_samples_wr_ctrl.sv
// -----------------------------------------------------------------------------
// rx_filtered_samples_wr_ctrl
// Write-side controller for the 16x512 filtered-sample BRAM (port A).
// Stores the rx FIR output stream in a circular buffer, pulses block_done
// whenever a BLOCK_LEN block is fully in RAM, lets the correlator lock the
// newest completed block against overwrite, and flags dropped samples.
//
// Lock FSM
//   state    | meaning
//   S_IDLE   | no lock requested
//   S_WAIT   | lock requested, no completed block yet; grant on next block_done
//   S_LOCKED | lock granted; writes into the locked block are dropped
//
// Ports
//   clk           system clock
//   rx_rst        asynchronous, active-high reset
//   sample_valid  filtered sample present this cycle
//   sample_data   filtered sample
//   bram_ena      BRAM port-A enable
//   bram_wea      BRAM port-A write enable
//   bram_addra    BRAM write address
//   bram_dia      BRAM write data
//   block_done    1-cycle pulse, a block is fully written
//   block_base    first address of the newest completed block
//   lock_req      reader lock request (level, held for the whole read)
//   lock_ack      lock granted, lock_base valid while high
//   lock_base     base address of the locked block
//   overrun       sticky, a sample was dropped
//   overrun_clr   clears overrun
// -----------------------------------------------------------------------------
module rx_filtered_samples_wr_ctrl
  import rx_filtered_samples_wr_ctrl_pkg::*;
#(
  parameter int DATA_W    = RX_FILT_DATA_W,
  parameter int ADDR_W    = RX_FILT_ADDR_W,
  parameter int BLOCK_LEN = RX_FILT_BLOCK_LEN
) (
  input  logic              clk,
  input  logic              rx_rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dia,
  output logic              block_done,
  output logic [ADDR_W-1:0] block_base,
  input  logic              lock_req,
  output logic              lock_ack,
  output logic [ADDR_W-1:0] lock_base,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int OFF_W = $clog2(BLOCK_LEN);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              bram_we_q, bram_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              block_done_q, block_done_d;
  logic [ADDR_W-1:0] block_base_q, block_base_d;
  logic              have_block_q, have_block_d;

  lock_state_e       state_q, state_d;
  logic              lock_ack_q, lock_ack_d;
  logic [ADDR_W-1:0] lock_base_q, lock_base_d;

  logic              overrun_q, overrun_d;

  logic              drop;
  logic              accept;
  logic              blk_end;

  // lock_base is always block-aligned, so "wr_ptr within
  // [lock_base, lock_base+BLOCK_LEN) modulo DEPTH" reduces to equal block index.
  assign drop    = (state_q == S_LOCKED) && sample_valid &&
                   (wr_ptr_q[ADDR_W-1:OFF_W] == lock_base_q[ADDR_W-1:OFF_W]);
  assign accept  = sample_valid && !drop;

  // The last address of a block is being written to RAM this cycle, so the
  // completion pulse registered from it is seen only once the data is stored.
  assign blk_end = bram_we_q && (&addr_q[OFF_W-1:0]);

  // Write path, block tracking and overrun next-state
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    bram_we_d    = accept;
    addr_d       = addr_q;
    data_d       = data_q;
    block_done_d = blk_end;
    block_base_d = block_base_q;
    have_block_d = have_block_q;
    overrun_d    = overrun_q;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      addr_d   = wr_ptr_q;
      data_d   = sample_data;
    end

    if (blk_end) begin
      block_base_d = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      have_block_d = 1'b1;
    end

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  // Lock FSM next-state. block_base_q already holds the new base in the
  // block_done cycle, so a request arriving then is granted the new block.
  always_comb begin
    state_d     = state_q;
    lock_base_d = lock_base_q;

    if (!lock_req) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (have_block_q) begin
            state_d     = S_LOCKED;
            lock_base_d = block_base_q;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (block_done_q) begin
            state_d     = S_LOCKED;
            lock_base_d = block_base_q;
          end
        end
        S_LOCKED: state_d = S_LOCKED;
        default:  state_d = S_IDLE;
      endcase
    end

    lock_ack_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk or posedge rx_rst) begin
    if (rx_rst) begin
      wr_ptr_q  <= '0;
      bram_we_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      bram_we_q <= bram_we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  always_ff @(posedge clk or posedge rx_rst) begin
    if (rx_rst) begin
      block_done_q <= 1'b0;
      block_base_q <= '0;
      have_block_q <= 1'b0;
    end else begin
      block_done_q <= block_done_d;
      block_base_q <= block_base_d;
      have_block_q <= have_block_d;
    end
  end

  always_ff @(posedge clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q     <= S_IDLE;
      lock_ack_q  <= 1'b0;
      lock_base_q <= '0;
    end else begin
      state_q     <= state_d;
      lock_ack_q  <= lock_ack_d;
      lock_base_q <= lock_base_d;
    end
  end

  always_ff @(posedge clk or posedge rx_rst) begin
    if (rx_rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign bram_ena   = bram_we_q;
  assign bram_wea   = bram_we_q;
  assign bram_addra = addr_q;
  assign bram_dia   = data_q;
  assign block_done = block_done_q;
  assign block_base = block_base_q;
  assign lock_ack   = lock_ack_q;
  assign lock_base  = lock_base_q;
  assign overrun    = overrun_q;

endmodule
